// File: rtl/ping_pong_monitor.sv
// ping_pong_monitor
//   Receive-side checker for a ping-pong counter stream (value + direction).
//   Locks onto the sampled sequence, predicts each next sample from min/max,
//   flags illegal steps, counts turnarounds and measures the bounce period
//   (moving samples between consecutive max turnarounds).
//
// Optional feature: define PPM_FLIP_TOL_EN to accept a mid-range direction
//   flip while tracking, i.e. (v,1)->(v-1,0) or (v,0)->(v+1,1) with min<v<max.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   sample_vld         sample_val/sample_dir valid this cycle
//   sample_val         observed counter value
//   sample_dir         observed direction (1=up, 0=down)
//   max, min           counter bounds; must stay static while locked
//   locked             1 while tracking
//   err                1-cycle pulse: illegal sample while tracking
//   bounce             1-cycle pulse: legal turnaround while tracking
//   err_cnt            saturating error count since reset
//   bounce_cnt         saturating turnaround count since reset
//   period             moving samples between the last two max turnarounds
//   period_vld         1-cycle pulse when period updates
module ping_pong_monitor #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_vld,
  input  logic [WIDTH-1:0] sample_val,
  input  logic             sample_dir,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  output logic             locked,
  output logic             err,
  output logic             bounce,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bounce_cnt,
  output logic [CNT_W-1:0] period,
  output logic             period_vld
);

  localparam int MW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  typedef enum logic [1:0] {EMPTY, ACQUIRE, TRACK} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ref_v, ref_v_nxt;
  logic             ref_d, ref_d_nxt;
  logic [MW-1:0]    match, match_nxt, match_inc;
  logic [CNT_W-1:0] pcnt, pcnt_nxt;
  logic             max_seen, max_seen_nxt;
  logic             err_nxt, bounce_nxt, pv_nxt;
  logic [CNT_W-1:0] err_cnt_nxt, bounce_cnt_nxt, period_nxt;

  // Sample classification against the reference; one extra bit so that
  // max=all-ones and min=0 never wrap.
  logic [WIDTH:0] v1, s1, max1, min1;
  logic cfg_ok, in_range, is_hold, step_up, step_dn, turn_max, turn_min;
  logic is_turn, is_move, is_flip, legal_acq, legal_trk;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

  always_comb begin
    v1       = {1'b0, ref_v};
    s1       = {1'b0, sample_val};
    max1     = {1'b0, max};
    min1     = {1'b0, min};
    cfg_ok   = max > min;
    in_range = (sample_val >= min) && (sample_val <= max);
    is_hold  = (sample_val == ref_v) && (sample_dir == ref_d);
    step_up  = ref_d && (ref_v < max) && sample_dir && (s1 == v1 + ONE);
    step_dn  = !ref_d && (ref_v > min) && !sample_dir && (s1 == v1 - ONE);
    turn_max = ref_d && (ref_v == max) && !sample_dir && (s1 == max1 - ONE);
    turn_min = !ref_d && (ref_v == min) && sample_dir && (s1 == min1 + ONE);
`ifdef PPM_FLIP_TOL_EN
    is_flip  = (ref_v > min) && (ref_v < max) &&
               (( ref_d && !sample_dir && (s1 == v1 - ONE)) ||
                (!ref_d &&  sample_dir && (s1 == v1 + ONE)));
`else
    is_flip  = 1'b0;
`endif
    is_turn   = turn_max || turn_min;
    is_move   = step_up || step_dn || is_turn;
    legal_acq = in_range && (is_hold || is_move);
    legal_trk = in_range && (is_hold || is_move || is_flip);
    match_inc = match + MW'(1);
  end

  always_comb begin
    state_nxt      = state;
    ref_v_nxt      = ref_v;
    ref_d_nxt      = ref_d;
    match_nxt      = match;
    pcnt_nxt       = pcnt;
    max_seen_nxt   = max_seen;
    err_nxt        = 1'b0;
    bounce_nxt     = 1'b0;
    pv_nxt         = 1'b0;
    err_cnt_nxt    = err_cnt;
    bounce_cnt_nxt = bounce_cnt;
    period_nxt     = period;

    if (!cfg_ok) begin
      state_nxt = EMPTY;
      match_nxt = '0;
    end else if (sample_vld) begin
      case (state)
        EMPTY: begin
          ref_v_nxt = sample_val;
          ref_d_nxt = sample_dir;
          match_nxt = '0;
          state_nxt = ACQUIRE;
        end
        ACQUIRE: begin
          if (!legal_acq) begin
            ref_v_nxt = sample_val;
            ref_d_nxt = sample_dir;
            match_nxt = '0;
          end else if (is_move) begin
            ref_v_nxt = sample_val;
            ref_d_nxt = sample_dir;
            match_nxt = match_inc;
            if (match_inc == MW'(LOCK_N)) begin
              state_nxt    = TRACK;
              pcnt_nxt     = '0;
              max_seen_nxt = 1'b0;
            end
          end
        end
        TRACK: begin
          if (!legal_trk) begin
            err_nxt     = 1'b1;
            err_cnt_nxt = sat_inc(err_cnt);
            ref_v_nxt   = sample_val;
            ref_d_nxt   = sample_dir;
            match_nxt   = '0;
            state_nxt   = ACQUIRE;
          end else if (is_move || is_flip) begin
            ref_v_nxt = sample_val;
            ref_d_nxt = sample_dir;
            pcnt_nxt  = sat_inc(pcnt);
            if (is_turn) begin
              bounce_nxt     = 1'b1;
              bounce_cnt_nxt = sat_inc(bounce_cnt);
            end
            // Period spans max turn to max turn and includes the closing turn.
            if (turn_max) begin
              if (max_seen) begin
                period_nxt = sat_inc(pcnt);
                pv_nxt     = 1'b1;
              end
              pcnt_nxt     = '0;
              max_seen_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ref_v      <= '0;
      ref_d      <= 1'b0;
      match      <= '0;
      pcnt       <= '0;
      max_seen   <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      bounce     <= 1'b0;
      err_cnt    <= '0;
      bounce_cnt <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      state      <= state_nxt;
      ref_v      <= ref_v_nxt;
      ref_d      <= ref_d_nxt;
      match      <= match_nxt;
      pcnt       <= pcnt_nxt;
      max_seen   <= max_seen_nxt;
      locked     <= (state_nxt == TRACK);
      err        <= err_nxt;
      bounce     <= bounce_nxt;
      err_cnt    <= err_cnt_nxt;
      bounce_cnt <= bounce_cnt_nxt;
      period     <= period_nxt;
      period_vld <= pv_nxt;
    end
  end

endmodule

// File: tb/tb_ping_pong_monitor.sv
// tb_ping_pong_monitor
//   Self-checking bench for ping_pong_monitor (WIDTH=4, CNT_W=8, LOCK_N=2).
//   Each test drives a table of samples; the expected registered outputs are
//   queued as each sample is driven and compared after the sampling edge.
module tb_ping_pong_monitor;

  typedef struct packed {
    logic       l;
    logic       e;
    logic       b;
    logic [7:0] ec;
    logic [7:0] bc;
    logic [7:0] per;
    logic       pv;
  } out_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] v;
    logic       d;
    out_t       o;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_vld = 1'b0;
  logic [3:0] sample_val = '0;
  logic       sample_dir = 1'b0;
  logic [3:0] max = 4'd5;
  logic [3:0] min = 4'd2;
  logic       locked, err, bounce, period_vld;
  logic [7:0] err_cnt, bounce_cnt, period;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  step_t stim[$];
  out_t obs;

  assign obs = {locked, err, bounce, err_cnt, bounce_cnt, period, period_vld};

  ping_pong_monitor #(.WIDTH(4), .CNT_W(8), .LOCK_N(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_vld (sample_vld),
    .sample_val (sample_val),
    .sample_dir (sample_dir),
    .max        (max),
    .min        (min),
    .locked     (locked),
    .err        (err),
    .bounce     (bounce),
    .err_cnt    (err_cnt),
    .bounce_cnt (bounce_cnt),
    .period     (period),
    .period_vld (period_vld)
  );

  always #5 clk = ~clk;

  function automatic step_t st(input logic vld, input logic [3:0] v, input logic d,
                               input logic l, input logic e, input logic b,
                               input int ec, input int bc, input int per, input logic pv);
    step_t s;
    s.vld = vld; s.v = v; s.d = d;
    s.o = {l, e, b, 8'(ec), 8'(bc), 8'(per), pv};
    return s;
  endfunction

  // Drive one sample (inputs change 1 time unit after the edge) and queue
  // the outputs it should produce; then wait for its sampling edge.
  task automatic apply(input step_t s);
    sample_vld = s.vld;
    sample_val = s.v;
    sample_dir = s.d;
    exp_q.push_back(s.o);
    @(posedge clk);
    #1;
    sample_vld = 1'b0;
  endtask

  task automatic do_reset(input logic [3:0] mn, input logic [3:0] mx);
    sample_vld = 1'b0;
    min = mn;
    max = mx;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    stim.delete();
  endtask

  task automatic test_reset;
    out_t ex;
    rst_n = 1'b0;
    #2;
    ex = '0;
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs, ex);
    end
    do_reset(4'd2, 4'd5);
  endtask

  task automatic test_lock_bounce;
    out_t ex;
    do_reset(4'd2, 4'd5);
    stim.push_back(st(1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 1, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 0, 1, 0, 1, 0, 1, 0, 0));
    stim.push_back(st(0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    foreach (stim[i]) begin
      apply(stim[i]);
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL lock_bounce[%0d] got=%h exp=%h", i, obs, ex);
      end
    end
  endtask

  task automatic test_period;
    out_t ex;
    do_reset(4'd2, 4'd5);
    stim.push_back(st(1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 1, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 0, 1, 0, 1, 0, 1, 0, 0));
    stim.push_back(st(1, 3, 0, 1, 0, 0, 0, 1, 0, 0));
    stim.push_back(st(1, 2, 0, 1, 0, 0, 0, 1, 0, 0));
    stim.push_back(st(1, 3, 1, 1, 0, 1, 0, 2, 0, 0));
    stim.push_back(st(1, 4, 1, 1, 0, 0, 0, 2, 0, 0));
    stim.push_back(st(1, 5, 1, 1, 0, 0, 0, 2, 0, 0));
    stim.push_back(st(1, 4, 0, 1, 0, 1, 0, 3, 6, 1));
    stim.push_back(st(1, 3, 0, 1, 0, 0, 0, 3, 6, 0));
    stim.push_back(st(1, 2, 0, 1, 0, 0, 0, 3, 6, 0));
    stim.push_back(st(1, 3, 1, 1, 0, 1, 0, 4, 6, 0));
    stim.push_back(st(1, 4, 1, 1, 0, 0, 0, 4, 6, 0));
    stim.push_back(st(1, 5, 1, 1, 0, 0, 0, 4, 6, 0));
    stim.push_back(st(1, 4, 0, 1, 0, 1, 0, 5, 6, 1));
    foreach (stim[i]) begin
      apply(stim[i]);
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL period[%0d] got=%h exp=%h", i, obs, ex);
      end
    end
  endtask

  task automatic test_error_relock;
    out_t ex;
    do_reset(4'd2, 4'd5);
    stim.push_back(st(1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 2, 0, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 3, 1, 1, 0, 1, 0, 1, 0, 0));
    stim.push_back(st(1, 5, 1, 0, 1, 0, 1, 1, 0, 0));
    stim.push_back(st(1, 9, 1, 0, 0, 0, 1, 1, 0, 0));
    stim.push_back(st(1, 4, 0, 0, 0, 0, 1, 1, 0, 0));
    stim.push_back(st(1, 3, 0, 0, 0, 0, 1, 1, 0, 0));
    stim.push_back(st(1, 2, 0, 1, 0, 0, 1, 1, 0, 0));
    stim.push_back(st(1, 3, 1, 1, 0, 1, 1, 2, 0, 0));
    foreach (stim[i]) begin
      apply(stim[i]);
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL error_relock[%0d] got=%h exp=%h", i, obs, ex);
      end
    end
  endtask

  task automatic test_hold;
    out_t ex;
    do_reset(4'd2, 4'd5);
    stim.push_back(st(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 0, 1, 0, 1, 0, 1, 0, 0));
    for (int k = 0; k < 5; k++) stim.push_back(st(1, 4, 0, 1, 0, 0, 0, 1, 0, 0));
    stim.push_back(st(1, 3, 0, 1, 0, 0, 0, 1, 0, 0));
    stim.push_back(st(1, 2, 0, 1, 0, 0, 0, 1, 0, 0));
    stim.push_back(st(1, 3, 1, 1, 0, 1, 0, 2, 0, 0));
    stim.push_back(st(1, 4, 1, 1, 0, 0, 0, 2, 0, 0));
    stim.push_back(st(1, 5, 1, 1, 0, 0, 0, 2, 0, 0));
    stim.push_back(st(1, 4, 0, 1, 0, 1, 0, 3, 6, 1));
    foreach (stim[i]) begin
      apply(stim[i]);
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL hold[%0d] got=%h exp=%h", i, obs, ex);
      end
    end
  endtask

  task automatic test_flip;
    out_t ex;
    do_reset(4'd2, 4'd5);
    stim.push_back(st(1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 2, 0, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 3, 1, 1, 0, 1, 0, 1, 0, 0));
`ifdef PPM_FLIP_TOL_EN
    stim.push_back(st(1, 2, 0, 1, 0, 0, 0, 1, 0, 0));
    stim.push_back(st(1, 3, 1, 1, 0, 1, 0, 2, 0, 0));
`else
    stim.push_back(st(1, 2, 0, 0, 1, 0, 1, 1, 0, 0));
    stim.push_back(st(1, 3, 1, 0, 0, 0, 1, 1, 0, 0));
`endif
    foreach (stim[i]) begin
      apply(stim[i]);
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL flip[%0d] got=%h exp=%h", i, obs, ex);
      end
    end
  endtask

  task automatic test_bad_cfg;
    out_t ex;
    do_reset(4'd2, 4'd5);
    stim.push_back(st(1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 1, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 2, 1, 0, 1, 0, 1, 0, 0, 0));
    // phase 1: min==max, phase 2: max<min, phase 3: valid bounds again
    for (int p = 0; p < 2; p++) begin
      stim.push_back(st(1, 3, 1, 0, 0, 0, 1, 0, 0, 0));
      stim.push_back(st(1, 4, 1, 0, 0, 0, 1, 0, 0, 0));
      stim.push_back(st(1, 5, 1, 0, 0, 0, 1, 0, 0, 0));
      stim.push_back(st(1, 9, 0, 0, 0, 0, 1, 0, 0, 0));
    end
    stim.push_back(st(1, 2, 1, 0, 0, 0, 1, 0, 0, 0));
    stim.push_back(st(1, 3, 1, 0, 0, 0, 1, 0, 0, 0));
    stim.push_back(st(1, 4, 1, 1, 0, 0, 1, 0, 0, 0));
    foreach (stim[i]) begin
      if (i == 4)  begin min = 4'd3; max = 4'd3; end
      if (i == 8)  begin min = 4'd5; max = 4'd2; end
      if (i == 12) begin min = 4'd2; max = 4'd5; end
      apply(stim[i]);
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL bad_cfg[%0d] got=%h exp=%h", i, obs, ex);
      end
    end
  endtask

  task automatic test_saturation;
    out_t ex;
    int   ec;
    do_reset(4'd2, 4'd5);
    apply(st(1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    ex = exp_q.pop_front();
    for (int k = 0; k < 258; k++) begin
      apply(st(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
      ex = exp_q.pop_front();
      apply(st(1, 4, 1, 0, 0, 0, 0, 0, 0, 0));
      ex = exp_q.pop_front();
      ec = (k + 1 > 255) ? 255 : k + 1;
      apply(st(1, 2, 1, 0, 1, 0, ec, 0, 0, 0));
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL err_sat[%0d] got=%h exp=%h", k, obs, ex);
      end
    end
  endtask

  task automatic test_async_reset;
    out_t ex;
    do_reset(4'd2, 4'd5);
    stim.push_back(st(1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 1, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 0, 1, 0, 1, 0, 1, 0, 0));
    foreach (stim[i]) begin
      apply(stim[i]);
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL async_pre[%0d] got=%h exp=%h", i, obs, ex);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    ex = '0;
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL async_clear got=%h exp=%h", obs, ex);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stim.delete();
    stim.push_back(st(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    stim.push_back(st(1, 4, 1, 1, 0, 0, 0, 0, 0, 0));
    foreach (stim[i]) begin
      apply(stim[i]);
      ex = exp_q.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL async_post[%0d] got=%h exp=%h", i, obs, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_bounce();
    test_period();
    test_error_relock();
    test_hold();
    test_flip();
    test_bad_cfg();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
